scmp_op_fetch: RTL and testbench

Instruction fetch sequencer that produces the opcode byte and optional displacement byte consumed by the SC/MP opcode decoder and microcode sequencer. On request it pre-increments the program counter (12-bit wrap within the current 4 KB page), reads the opcode over the byte-wide memory handshake, and, for two-byte instructions (opcode bit 7 set), fetches the displacement byte. It sits between the microcode sequencer, the PC register path and the external memory bus interface.

---
 rtl/scmp_op_fetch_if.sv | 22 ++
 rtl/scmp_op_fetch.sv | 143 ++++++++++++++
 tb/tb_scmp_op_fetch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scmp_op_fetch_if.sv
// Byte-wide memory read handshake between the fetch sequencer and the bus.
// master: drives mem_rd/mem_addr; slave: returns mem_ack/mem_rdata.
interface scmp_op_fetch_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/scmp_op_fetch.sv
// SC/MP instruction fetch: pre-incremented PC (12-bit page wrap), opcode
// read and optional displacement read over the byte-wide memory handshake.
// Ports: clk, rst_n (async low); fetch_req, pc_ld, pc_d from the sequencer;
// pc; mem (master side of scmp_op_fetch_if); op, disp, two_byte latched
// fields; fetch_done / fetch_err one-cycle pulses; busy when not idle.
module scmp_op_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_req,
    input  logic            pc_ld,
    input  logic [15:0]     pc_d,
    output logic [15:0]     pc,
    scmp_op_fetch_if.master mem,
    output logic [7:0]      op,
    output logic [7:0]      disp,
    output logic            two_byte,
    output logic            fetch_done,
    output logic            fetch_err,
    output logic            busy
);
    typedef enum logic [1:0] {
        IDLE,
        RD_OP,
        RD_DISP,
        DONE
    } state_t;

    // The abort fires on the cycle the counter would reach TIMEOUT.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam bit          TO_EN     = (TIMEOUT != 0);

    state_t      state_q, state_n;
    logic [15:0] pc_q, pc_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  op_q, op_n;
    logic [7:0]  disp_q, disp_n;
    logic        two_q, two_n;
    logic [15:0] cnt_q, cnt_n;
    logic        err_q, err_n;
    logic [15:0] base;
    logic        expired;

    function automatic logic [15:0] pc_inc(input logic [15:0] a);
        return {a[15:12], a[11:0] + 12'd1};
    endfunction

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        addr_n  = addr_q;
        op_n    = op_q;
        disp_n  = disp_q;
        two_n   = two_q;
        cnt_n   = cnt_q;
        err_n   = 1'b0;
        // A same-cycle load feeds the increment.
        base    = pc_ld ? pc_d : pc_q;
        expired = TO_EN && (cnt_q == WAIT_LAST);
        unique case (state_q)
            IDLE: begin
                pc_n = base;
                if (fetch_req) begin
                    pc_n    = pc_inc(base);
                    addr_n  = pc_inc(base);
                    cnt_n   = '0;
                    state_n = RD_OP;
                end
            end
            RD_OP: begin
                if (mem.mem_ack) begin
                    op_n  = mem.mem_rdata;
                    two_n = mem.mem_rdata[7];
                    if (mem.mem_rdata[7]) begin
                        pc_n    = pc_inc(pc_q);
                        addr_n  = pc_inc(pc_q);
                        cnt_n   = '0;
                        state_n = RD_DISP;
                    end else begin
                        disp_n  = 8'h00;
                        state_n = DONE;
                    end
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            RD_DISP: begin
                if (mem.mem_ack) begin
                    disp_n  = mem.mem_rdata;
                    state_n = DONE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 16'h0000;
            addr_q  <= 16'h0000;
            op_q    <= 8'h00;
            disp_q  <= 8'h00;
            two_q   <= 1'b0;
            cnt_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            addr_q  <= addr_n;
            op_q    <= op_n;
            disp_q  <= disp_n;
            two_q   <= two_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    // Every output below comes from registers only.
    assign mem.mem_rd   = (state_q == RD_OP) || (state_q == RD_DISP);
    assign mem.mem_addr = addr_q;
    assign pc           = pc_q;
    assign op           = op_q;
    assign disp         = disp_q;
    assign two_byte     = two_q;
    assign fetch_done   = (state_q == DONE);
    assign fetch_err    = err_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_scmp_op_fetch.sv
// Scoreboard bench for scmp_op_fetch: directed cases then random fetches
// against a byte-array memory with configurable wait states.
module tb_scmp_op_fetch;
    localparam int TO = 4;

    typedef struct {
        bit          err;
        logic [15:0] pc;
        logic [7:0]  op;
        logic [7:0]  disp;
        bit          two;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_ld;
    logic [15:0] pc_d;
    logic [15:0] pc;
    logic [7:0]  op;
    logic [7:0]  disp;
    logic        two_byte;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;

    scmp_op_fetch_if mif();

    scmp_op_fetch #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pc_ld      (pc_ld),
        .pc_d       (pc_d),
        .pc         (pc),
        .mem        (mif),
        .op         (op),
        .disp       (disp),
        .two_byte   (two_byte),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .busy       (busy)
    );

    logic [7:0]  mem_arr [65536];
    exp_t        exp_q [$];
    logic [15:0] addr_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cfg_wop = 0;
    int          cfg_wd = 0;
    bit          abort = 0;

    logic [15:0] m_pc;
    logic [7:0]  m_op;
    logic [7:0]  m_disp;
    bit          m_two;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] page_inc(input logic [15:0] a);
        return (a & 16'hF000) | ((a + 16'd1) & 16'h0FFF);
    endfunction

    // Memory slave: first read of a fetch waits cfg_wop cycles, second
    // waits cfg_wd; stray acks are thrown in while no read is pending.
    initial begin
        int wcnt;
        int nread;
        int w;
        wcnt = 0;
        nread = 0;
        mif.mem_ack = 0;
        mif.mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (!busy) nread = 0;
            if (mif.mem_rd) begin
                w = (nread == 0) ? cfg_wop : cfg_wd;
                if (wcnt >= w) begin
                    mif.mem_ack = 1;
                    mif.mem_rdata = mem_arr[mif.mem_addr];
                    wcnt = 0;
                    nread++;
                end else begin
                    mif.mem_ack = 0;
                    mif.mem_rdata = 8'($urandom);
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                mif.mem_ack = ($urandom_range(0, 3) == 0);
                mif.mem_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: addresses at each completed read, results at each pulse.
    initial begin
        exp_t        e;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (mif.mem_rd && mif.mem_ack) begin
                    if (addr_q.size() == 0) begin
                        chk("unexpected_read", {16'h0, mif.mem_addr}, 32'hFFFFFFFF);
                    end else begin
                        a = addr_q.pop_front();
                        chk("mem_addr", {16'h0, mif.mem_addr}, {16'h0, a});
                    end
                end
                if (fetch_done || fetch_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'h0, fetch_err, fetch_done}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("kind", {30'h0, fetch_err, fetch_done},
                            e.err ? 32'h2 : 32'h1);
                        chk("latency", cyc, e.cyc);
                        chk("pc", {16'h0, pc}, {16'h0, e.pc});
                        chk("op", {24'h0, op}, {24'h0, e.op});
                        chk("disp", {24'h0, disp}, {24'h0, e.disp});
                        chk("two_byte", {31'h0, two_byte}, {31'h0, e.two});
                    end
                end
            end
        end
    end

    // Reference: what one fetch yields, given start PC and wait states.
    task automatic model(input bit ld, input logic [15:0] pcd,
                         input int wo, input int wd, input int c);
        exp_t        e;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [7:0]  b;
        a1 = page_inc(ld ? pcd : m_pc);
        m_pc = a1;
        e.err = 0;
        if (wo >= TO) begin
            e.err = 1;
            e.cyc = c + 1 + TO;
        end else begin
            b = mem_arr[a1];
            addr_q.push_back(a1);
            m_op = b;
            m_two = (b >= 8'h80);
            if (!m_two) begin
                m_disp = 8'h00;
                e.cyc = c + 2 + wo;
            end else begin
                a2 = page_inc(a1);
                m_pc = a2;
                if (wd >= TO) begin
                    e.err = 1;
                    e.cyc = c + 2 + wo + TO;
                end else begin
                    addr_q.push_back(a2);
                    m_disp = mem_arr[a2];
                    e.cyc = c + 3 + wo + wd;
                end
            end
        end
        e.pc = m_pc;
        e.op = m_op;
        e.disp = m_disp;
        e.two = m_two;
        exp_q.push_back(e);
    endtask

    task automatic do_fetch(input bit ld, input logic [15:0] pcd,
                            input int wo, input int wd, input bit pulse);
        cfg_wop = wo;
        cfg_wd = wd;
        fetch_req = 1;
        pc_ld = ld;
        pc_d = pcd;
        model(ld, pcd, wo, wd, cyc);
        @(negedge clk);
        fetch_req = 0;
        pc_ld = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            if (pulse || $urandom_range(0, 3) == 0) begin
                fetch_req = 1'($urandom);
                pc_ld = 1'($urandom);
                pc_d = 16'($urandom);
            end else begin
                fetch_req = 0;
                pc_ld = 0;
            end
            @(negedge clk);
        end
        fetch_req = 0;
        pc_ld = 0;
        chk("busy_bound", {31'h0, busy}, 32'h0);
        if (busy) abort = 1;
    endtask

    task automatic load(input logic [15:0] v);
        pc_ld = 1;
        pc_d = v;
        fetch_req = 0;
        m_pc = v;
        @(negedge clk);
        pc_ld = 0;
        chk("pc_load", {16'h0, pc}, {16'h0, v});
    endtask

    initial begin
        rst_n = 0;
        fetch_req = 0;
        pc_ld = 0;
        pc_d = 0;
        m_pc = 0;
        m_op = 0;
        m_disp = 0;
        m_two = 0;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_op", {24'h0, op}, 32'h0);
        chk("rst_disp", {24'h0, disp}, 32'h0);
        chk("rst_two", {31'h0, two_byte}, 32'h0);
        chk("rst_rd", {31'h0, mif.mem_rd}, 32'h0);
        chk("rst_addr", {16'h0, mif.mem_addr}, 32'h0);
        chk("rst_done", {31'h0, fetch_done}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Reset in the middle of an opcode read.
        cfg_wop = 5;
        pc_ld = 1;
        pc_d = 16'h1234;
        fetch_req = 1;
        @(negedge clk);
        fetch_req = 0;
        pc_ld = 0;
        @(negedge clk);
        chk("rd_in_op", {31'h0, mif.mem_rd}, 32'h1);
        rst_n = 0;
        #1;
        chk("rst_mid_rd", {31'h0, mif.mem_rd}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_pc", {16'h0, pc}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // One-byte fetch, zero wait.
        load(16'h1000);
        mem_arr[16'h1001] = 8'h08;
        do_fetch(0, 16'h0, 0, 0, 0);

        // Two-byte fetch, two waits per read.
        mem_arr[16'h1002] = 8'hC4;
        mem_arr[16'h1003] = 8'h5A;
        if (!abort) do_fetch(0, 16'h0, 2, 2, 0);

        // Displacement read wraps within the page.
        load(16'h2FFE);
        mem_arr[16'h2FFF] = 8'h90;
        mem_arr[16'h2000] = 8'h10;
        if (!abort) do_fetch(0, 16'h0, 0, 0, 0);

        // Load and fetch together; requests pulsed while busy.
        mem_arr[16'h3000] = 8'h21;
        if (!abort) do_fetch(1, 16'h3FFF, 2, 0, 1);

        // Opcode timeout, then ack on the last allowed wait cycle.
        if (!abort) do_fetch(0, 16'h0, 5, 0, 0);
        mem_arr[16'h3002] = 8'h05;
        if (!abort) do_fetch(0, 16'h0, TO - 1, 0, 0);

        // Displacement timeout keeps the new opcode.
        mem_arr[16'h3003] = 8'hA7;
        if (!abort) do_fetch(0, 16'h0, 1, 5, 0);

        for (int n = 0; n < 200 && !abort; n++) begin
            if ($urandom_range(0, 4) == 0) load(16'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            do_fetch(1'($urandom), 16'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 5), 0);
        end

        repeat (5) @(negedge clk);
        chk("exp_left", exp_q.size(), 0);
        chk("addr_left", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
